// File: rtl/probe_top_pkg.sv
// probe_top_pkg: shared defaults and count type for the probe counter
package probe_top_pkg;
  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_INIT  = 0;
  localparam int DEFAULT_STEP  = 1;
  typedef logic [DEFAULT_WIDTH-1:0] count_t;
endpackage

// File: rtl/probe_top.sv
// probe_top: free-running counter with stable top-scope names r and out for probing and forcing
module probe_top
  import probe_top_pkg::*;
#(
  parameter int               WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(DEFAULT_INIT),
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(DEFAULT_STEP)
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_d;
  // next state reads r (never out) so a forced r is what the counter continues from
  always_comb r_d = reset_n ? r + STEP : INIT;
  always_ff @(posedge clock) r <= r_d;
  assign out = r;
endmodule

// File: tb/tb_probe_top.sv
// tb_probe_top: vector table, force/release sequences and randomized run against a counting model
module tb_probe_top;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] out;
  int          checks = 0;
  int          errors = 0;
  int          model = 0;

  typedef struct {
    bit          rn;
    logic [15:0] exp;
  } vec_t;

  probe_top dut (.clock(clock), .reset_n(reset_n), .out(out));

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: reset loads INIT, otherwise add STEP modulo 2^16
  task automatic tick();
    @(posedge clock);
    model = reset_n ? (model + 1) % 65536 : 0;
    #1;
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{1'b0, 16'h0000};
    vecs[1] = '{1'b0, 16'h0000};
    vecs[2] = '{1'b1, 16'h0001};
    vecs[3] = '{1'b1, 16'h0002};
    vecs[4] = '{1'b1, 16'h0003};
    #1;
    foreach (vecs[i]) begin
      reset_n = vecs[i].rn;
      tick();
      check($sformatf("reset_vec%0d", i), out, vecs[i].exp);
    end

    force dut.r = 16'hFFFE;
    #1;
    check("preload_forced", out, 16'hFFFE);
    release dut.r;
    #1;
    check("preload_released", out, 16'hFFFE);
    model = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("wrap%0d", i), out, 16'(model));
    end
    check("wrap_end", out, 16'h0001);

    for (int c = 1; c <= 3; c++) begin
      force dut.r = 16'(c);
      #1;
      check($sformatf("force_r%0d", c), dut.r, 16'(c));
      check($sformatf("force_out%0d", c), out, 16'(c));
      tick();
      check($sformatf("force_hold%0d", c), dut.r, 16'(c));
    end
    release dut.r;

    force dut.r = 16'h0003;
    force dut.out = 16'h007B;
    #1;
    check("iso_r", dut.r, 16'h0003);
    check("iso_out", out, 16'h007B);
    @(posedge clock);
    #1;
    check("iso_r_hold", dut.r, 16'h0003);
    check("iso_out_hold", out, 16'h007B);
    release dut.r;
    release dut.out;
    tick();
    check("iso_release", out, 16'h0004);
    model = 4;

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    while (out != 16'h0010 && model < 40) tick();
    check("count_to_10", out, 16'h0010);
    reset_n = 1'b0;
    tick();
    check("midreset", out, 16'h0000);
    reset_n = 1'b1;
    tick();
    check("midreset_resume", out, 16'h0001);

    tick();
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    check("glitch_nochange", out, 16'h0002);
    tick();
    check("glitch_count", out, 16'h0003);

    for (int i = 0; i < 300; i++) begin
      reset_n = ($urandom_range(0, 19) != 0);
      tick();
      check($sformatf("rand%0d", i), out, 16'(model));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
